aes_encrypt_seq: RTL and testbench

AES_ENCRYPT_SEQ -- requirements
Module: aes_encrypt_seq

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_encrypt_seq_if.sv | 20 ++
 rtl/enc_round.sv | 37 +++
 rtl/aes_encrypt_seq.sv | 109 ++++++++++
 tb/tb_aes_encrypt_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM state encoding, round count, forward S-box
// and the GF(2^8) helpers used by the round datapath.
package aes_pkg;

  localparam int NR = 10;

  // Two legal states; the spare encodings exist so a corrupted state register
  // is detectable and falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8), reducing with x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; col[31:24] is the row-0 byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_encrypt_seq_if.sv
// Request/result bundle for the sequential AES-128 encryptor.
interface aes_encrypt_seq_if
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input logic clk
);
  logic                      start;
  logic [127:0]              data;
  logic [128*(NR+1)-1:0]     key;
  logic                      busy;
  logic                      done;
  logic [127:0]              cipherText;

  modport master (input clk, output start, output data, output key,
                  input busy, input done, input cipherText);
  modport slave  (input clk, input start, input data, input key,
                  output busy, output done, output cipherText);
endinterface

// File: rtl/enc_round.sv
// Combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns (skipped on the final round) and AddRoundKey.
// Byte i of a 128-bit word sits at [127-8*i -: 8]; byte i is row i%4, column i/4.
module enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [127:0] sub_bytes;
  logic [127:0] shift_rows;
  logic [127:0] mix_cols;

  // Byte substitution, row rotation, column mixing and key addition.
  always_comb begin
    sub_bytes  = '0;
    shift_rows = '0;
    mix_cols   = '0;
    for (int i = 0; i < 16; i++) begin
      sub_bytes[127-8*i -: 8] = SBOX[state_in[127-8*i -: 8]];
    end
    // Row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_rows[127-8*(r+4*c) -: 8] = sub_bytes[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_cols[127-32*c -: 32] = mix_column(shift_rows[127-32*c -: 32]);
    end
    state_out = (last_round ? shift_rows : mix_cols) ^ round_key;
  end

endmodule

// File: rtl/aes_encrypt_seq.sv
// Iterative AES-128 encryptor: one round per clock through a single shared
// round datapath, 11 edges from the accepting edge to the done pulse.
module aes_encrypt_seq
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [127:0]          data,
  input  logic [128*(NR+1)-1:0] key,
  output logic                  busy,
  output logic                  done,
  output logic [127:0]          cipherText
);

  state_e       fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] ct_q, ct_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  logic [127:0] round_key;
  logic         last_round;
  logic [127:0] round_out;

  // Select round key rnd from the expanded schedule; out-of-range rnd gives zero.
  always_comb begin
    round_key = '0;
    for (int r = 0; r <= NR; r++) begin
      if (rnd_q == 4'(r)) round_key = key[128*r +: 128];
    end
  end

  assign last_round = (rnd_q == 4'(NR));

  enc_round u_round (
    .state_in   (blk_q),
    .round_key  (round_key),
    .last_round (last_round),
    .state_out  (round_out)
  );

  // Next-state logic: accept in IDLE, iterate rounds in RUN, recover from illegal values.
  always_comb begin
    fsm_d  = fsm_q;
    rnd_d  = rnd_q;
    blk_d  = blk_q;
    ct_d   = ct_q;
    done_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        rnd_d = 4'd0;
        if (start) begin
          // Initial AddRoundKey with round key 0; data is only looked at here.
          blk_d = data ^ key[127:0];
          rnd_d = 4'd1;
          fsm_d = RUN;
        end
      end
      RUN: begin
        if (rnd_q >= 4'd1 && rnd_q < 4'(NR)) begin
          blk_d = round_out;
          rnd_d = rnd_q + 4'd1;
        end else if (last_round) begin
          blk_d  = round_out;
          ct_d   = round_out;
          done_d = 1'b1;
          rnd_d  = 4'd0;
          fsm_d  = IDLE;
        end else begin
          rnd_d = 4'd0;
          fsm_d = IDLE;
        end
      end
      default: begin
        rnd_d = 4'd0;
        fsm_d = IDLE;
      end
    endcase
    busy_d = (fsm_d == RUN);
  end

  // State, counter, datapath and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q  <= IDLE;
      rnd_q  <= 4'd0;
      blk_q  <= '0;
      ct_q   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      blk_q  <= blk_d;
      ct_q   <= ct_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign cipherText = ct_q;

endmodule

// File: tb/tb_aes_encrypt_seq.sv
// Bench for aes_encrypt_seq: a byte-matrix AES reference (S-box derived from
// the GF(2^8) inverse and affine map) drives a cycle-level expectation that is
// compared with the DUT every cycle, plus FIPS-197 literal vectors.
module tb_aes_encrypt_seq;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [127:0] ck;
  logic [7:0]   sb_m [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_encrypt_seq_if #(.NR(10)) ifc (.clk(clk));

  aes_encrypt_seq #(.NR(10)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (ifc.start),
    .data       (ifc.data),
    .key        (ifc.key),
    .busy       (ifc.busy),
    .done       (ifc.done),
    .cipherText (ifc.cipherText)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine transform.
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [1407:0] out;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]], sb_m[t[31:24]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) out[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return out;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [1407:0] rk;
    logic [7:0] m [4][4];
    logic [7:0] t [4][4];
    logic [127:0] out;
    rk = expand(k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = pt[127-8*(r+4*c) -: 8] ^ rk[127-8*(r+4*c) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb_m[m[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rd < 10)
            m[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            m[r][c] = t[r][c];
          m[r][c] = m[r][c] ^ rk[128*rd + 127 - 8*(r+4*c) -: 8];
        end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        out[127-8*(r+4*c) -: 8] = m[r][c];
    return out;
  endfunction

  // Cycle-level expectation: accept when idle, result appears 10 edges after accept.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [127:0] m_ct = '0;
  logic [127:0] m_res = '0;
  int           m_left = 0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_ct = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_ct = m_res;
        end
      end else if (ifc.start) begin
        m_busy = 1'b1; m_left = 10; m_res = aes_ref(ifc.data, ck);
      end
    end
  end

  // Per-cycle comparison of outputs against the expectation.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc busy", {127'b0, ifc.busy}, {127'b0, m_busy});
      chk("cyc done", {127'b0, ifc.done}, {127'b0, m_done});
      chk("cyc cipherText", ifc.cipherText, m_ct);
    end
  end

  task automatic wait_done(output int when, output logic ok);
    ok = 1'b0; when = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ifc.done) begin ok = 1'b1; when = cyc; break; end
    end
  endtask

  task automatic run_one(input string nm, input logic [127:0] pt, input logic [127:0] exp_ct,
                         input logic chg_data);
    int c0, cd; logic ok;
    @(negedge clk); ifc.data = pt; ifc.start = 1'b1;
    @(posedge clk); #1; c0 = cyc;
    @(negedge clk); ifc.start = 1'b0;
    if (chg_data) ifc.data = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    wait_done(cd, ok);
    chk({nm, " done seen"}, {127'b0, ok}, 128'd1);
    chk({nm, " latency edges"}, 128'(cd - c0 + 1), 128'd11);
    chk({nm, " cipherText"}, ifc.cipherText, exp_ct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, d1, d2, cnt;
    logic ok1, ok2;
    ifc.start = 1'b0;
    ifc.data  = '0;
    build_sbox();
    ck = KEY_B;
    ifc.key = expand(KEY_B);

    // Pin the reference model itself.
    chk("model sbox[00]", {120'b0, sb_m[0]}, 128'h63);
    chk("model sbox[53]", {120'b0, sb_m[8'h53]}, 128'hed);
    chk("model rk10", ifc.key[1407:1280], RK10_B);
    chk("model AppB", aes_ref(PT_B, KEY_B), CT_B);
    chk("model AppC1", aes_ref(PT_C, KEY_C), CT_C);

    // Asynchronous reset before any clock edge.
    #2 n_rst = 1'b0;
    #1;
    chk("reset busy", {127'b0, ifc.busy}, 128'd0);
    chk("reset done", {127'b0, ifc.done}, 128'd0);
    chk("reset cipherText", ifc.cipherText, 128'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    run_one("AppB", PT_B, CT_B, 1'b0);

    @(negedge clk); ck = KEY_C; ifc.key = expand(KEY_C);
    run_one("AppC1", PT_C, CT_C, 1'b0);

    // Back-to-back with start held through done.
    @(negedge clk); ck = KEY_B; ifc.key = expand(KEY_B);
    ifc.data = PT_B; ifc.start = 1'b1;
    @(posedge clk); #1; c0 = cyc;
    wait_done(d1, ok1);
    chk("b2b first done", {127'b0, ok1}, 128'd1);
    chk("b2b first latency", 128'(d1 - c0 + 1), 128'd11);
    chk("b2b busy in done cycle", {127'b0, ifc.busy}, 128'd0);
    @(posedge clk); #1;
    chk("b2b busy after restart", {127'b0, ifc.busy}, 128'd1);
    wait_done(d2, ok2);
    ifc.start = 1'b0;
    chk("b2b second done", {127'b0, ok2}, 128'd1);
    chk("b2b spacing", 128'(d2 - d1), 128'd11);
    chk("b2b cipherText", ifc.cipherText, CT_B);
    repeat (3) @(negedge clk);

    // Start pulsed mid-run with other data is ignored.
    @(negedge clk); ifc.data = PT_B; ifc.start = 1'b1;
    @(posedge clk); #1; c0 = cyc;
    @(negedge clk); ifc.start = 1'b0;
    repeat (4) @(negedge clk);
    ifc.data = PT_C; ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0;
    wait_done(d1, ok1);
    chk("busystart done", {127'b0, ok1}, 128'd1);
    chk("busystart latency", 128'(d1 - c0 + 1), 128'd11);
    chk("busystart cipherText", ifc.cipherText, CT_B);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ifc.done) cnt++;
    end
    chk("busystart extra dones", 128'(cnt), 128'd0);
    chk("busystart busy after", {127'b0, ifc.busy}, 128'd0);

    // Reset dropped in the sixth RUN cycle aborts the block.
    @(negedge clk); ifc.data = PT_B; ifc.start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); ifc.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midreset busy", {127'b0, ifc.busy}, 128'd0);
    chk("midreset done", {127'b0, ifc.done}, 128'd0);
    chk("midreset cipherText", ifc.cipherText, 128'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ifc.done) cnt++;
    end
    chk("midreset no done", 128'(cnt), 128'd0);
    chk("midreset cipherText after", ifc.cipherText, 128'd0);

    // Data altered the cycle after start does not disturb the result.
    run_one("datachange", PT_B, CT_B, 1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
